// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage data-memory handshake. It stalls the pipeline from the
//            point an access is seen until the memory acknowledges it.
// Options  : MEM_TIMEOUT_EN adds a WAIT-cycle limit and a sticky err_o.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        stall_o,
    output logic [31:0] MemData_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   access;
    logic   stall;

`ifdef MEM_TIMEOUT_EN
    // The access is aborted on the WAIT cycle that would take the count to TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       timeout_hit;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign access = MemRead_i | MemWrite_i;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (access) begin
                    state_nxt = WAIT;
                    stall     = 1'b1;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_cnt == TMO_LAST) begin
                    state_nxt   = DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by reset so that a held request cannot raise stall while in reset.
    assign stall_o = stall & rst_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            MemData_o   <= '0;
        end else begin
            state     <= state_nxt;
            mem_req_o <= (state_nxt == WAIT);
            if (state == IDLE && access) begin
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
                mem_we_o    <= MemWrite_i;
            end else if (state_nxt != WAIT) begin
                mem_we_o <= 1'b0;
            end
            if (state == WAIT && mem_ack_i && !mem_we_o) begin
                MemData_o <= mem_rdata_i;
            end
`ifdef MEM_TIMEOUT_EN
            else if (timeout_hit && !mem_we_o) begin
                MemData_o <= 32'hDEADBEEF;
            end
`endif
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else if (!mem_ack_i) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout_hit) begin
                err_o <= 1'b1;
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        stall_o;
    logic [31:0] MemData_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_total = 0;
    int stall_base;

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .stall_o     (stall_o),
        .MemData_o   (MemData_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (stall_o === 1'b1) stall_total <= stall_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are driven 2 time units after the rising edge, outputs checked 1 later.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_ack_i  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'd0, mem_req_o}, 32'd0);
        check({tag, "_we"},    {31'd0, mem_we_o},  32'd0);
        check({tag, "_stall"}, {31'd0, stall_o},   32'd0);
        check({tag, "_addr"},  mem_addr_o,  32'd0);
        check({tag, "_wdata"}, mem_wdata_o, 32'd0);
        check({tag, "_data"},  MemData_o,   32'd0);
        check({tag, "_err"},   {31'd0, err_o},     32'd0);
    endtask

    initial begin
        // Reset with a request held high: everything must stay zero.
        MemRead_i = 1'b1;
        addr_i    = 32'h0000_0099;
        repeat (2) step();
        settle();
        check_all_zero("reset");
        idle_inputs();
        #1 rst_i = 1'b1;

        // Ack outside WAIT is ignored.
        step();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_1111;
        step();
        settle();
        check("ack_idle_req", {31'd0, mem_req_o}, 32'd0);
        check("ack_idle_data", MemData_o, 32'd0);
        mem_ack_i = 1'b0;

        // Read 0x10, immediate ack.
        step();
        stall_base = stall_total;
        MemRead_i = 1'b1;
        addr_i    = 32'h0000_0010;
        settle();
        check("rd_c0_stall", {31'd0, stall_o}, 32'd1);
        check("rd_c0_req", {31'd0, mem_req_o}, 32'd0);
        step();
        MemRead_i   = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1234_5678;
        settle();
        check("rd_wait_req", {31'd0, mem_req_o}, 32'd1);
        check("rd_wait_we", {31'd0, mem_we_o}, 32'd0);
        check("rd_wait_addr", mem_addr_o, 32'h0000_0010);
        step();
        mem_ack_i = 1'b0;
        settle();
        check("rd_done_req", {31'd0, mem_req_o}, 32'd0);
        check("rd_done_stall", {31'd0, stall_o}, 32'd0);
        check("rd_done_data", MemData_o, 32'h1234_5678);
        check("rd_stall_cycles", stall_total - stall_base, 32'd2);

        // Write 0xCAFEF00D to 0x20, ack 5 cycles late.
        step();
        stall_base = stall_total;
        MemWrite_i = 1'b1;
        addr_i     = 32'h0000_0020;
        wdata_i    = 32'hCAFE_F00D;
        for (int i = 0; i < 6; i++) begin
            step();
            MemWrite_i = 1'b0;
            addr_i     = 32'h0;
            wdata_i    = 32'h0;
            mem_ack_i  = (i == 5);
            settle();
            check("wr_wait_req", {31'd0, mem_req_o}, 32'd1);
            check("wr_wait_we", {31'd0, mem_we_o}, 32'd1);
            check("wr_wait_wdata", mem_wdata_o, 32'hCAFE_F00D);
            check("wr_wait_addr", mem_addr_o, 32'h0000_0020);
        end
        step();
        mem_ack_i = 1'b0;
        settle();
        check("wr_done_req", {31'd0, mem_req_o}, 32'd0);
        check("wr_done_data", MemData_o, 32'h1234_5678);
        check("wr_stall_cycles", stall_total - stall_base, 32'd7);

        // Read and write together is a write; request held through DONE.
        step();
        MemRead_i  = 1'b1;
        MemWrite_i = 1'b1;
        addr_i     = 32'h0000_0030;
        wdata_i    = 32'h0BAD_F00D;
        step();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_5555;
        settle();
        check("both_we", {31'd0, mem_we_o}, 32'd1);
        step();
        mem_ack_i = 1'b0;
        settle();
        check("both_done_req", {31'd0, mem_req_o}, 32'd0);
        check("both_done_stall", {31'd0, stall_o}, 32'd0);
        check("both_data", MemData_o, 32'h1234_5678);
        idle_inputs();
        step();
        settle();
        check("both_no_reissue", {31'd0, mem_req_o}, 32'd0);

        // Reset asserted in the third WAIT cycle.
        step();
        MemRead_i = 1'b1;
        addr_i    = 32'h0000_0040;
        step();
        MemRead_i = 1'b0;
        step();
        step();
        settle();
        check("rst_pre_req", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check_all_zero("rst_wait");
        #1 rst_i = 1'b1;
        step();
        settle();
        check("rst_after_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_after_stall", {31'd0, stall_o}, 32'd0);

        // Back-to-back reads at 0x0 and 0x4.
        step();
        MemRead_i = 1'b1;
        addr_i    = 32'h0000_0000;
        step();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hAAAA_0001;
        settle();
        check("b2b_a_req", {31'd0, mem_req_o}, 32'd1);
        check("b2b_a_addr", mem_addr_o, 32'h0000_0000);
        step();
        mem_ack_i = 1'b0;
        addr_i    = 32'h0000_0004;
        settle();
        check("b2b_done_req", {31'd0, mem_req_o}, 32'd0);
        check("b2b_a_data", MemData_o, 32'hAAAA_0001);
        step();
        settle();
        check("b2b_idle_req", {31'd0, mem_req_o}, 32'd0);
        check("b2b_idle_stall", {31'd0, stall_o}, 32'd1);
        step();
        MemRead_i   = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBBBB_0002;
        settle();
        check("b2b_b_req", {31'd0, mem_req_o}, 32'd1);
        check("b2b_b_addr", mem_addr_o, 32'h0000_0004);
        step();
        mem_ack_i = 1'b0;
        settle();
        check("b2b_b_data", MemData_o, 32'hBBBB_0002);

`ifdef MEM_TIMEOUT_EN
        // Ack on the last allowed WAIT cycle wins over the timeout.
        step();
        MemRead_i = 1'b1;
        addr_i    = 32'h0000_0050;
        for (int i = 0; i < TMO; i++) begin
            step();
            MemRead_i   = 1'b0;
            mem_ack_i   = (i == TMO - 1);
            mem_rdata_i = 32'h7777_0007;
        end
        step();
        mem_ack_i = 1'b0;
        settle();
        check("tmo_race_data", MemData_o, 32'h7777_0007);
        check("tmo_race_err", {31'd0, err_o}, 32'd0);

        // Read with no ack aborts after TIMEOUT WAIT cycles.
        step();
        MemRead_i = 1'b1;
        addr_i    = 32'h0000_0060;
        for (int i = 0; i < TMO; i++) begin
            step();
            MemRead_i = 1'b0;
            settle();
            check("tmo_wait_req", {31'd0, mem_req_o}, 32'd1);
        end
        step();
        settle();
        check("tmo_done_req", {31'd0, mem_req_o}, 32'd0);
        check("tmo_data", MemData_o, 32'hDEAD_BEEF);
        check("tmo_err", {31'd0, err_o}, 32'd1);

        // A later good read keeps err_o set.
        step();
        MemRead_i = 1'b1;
        step();
        MemRead_i   = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h8888_0008;
        step();
        mem_ack_i = 1'b0;
        settle();
        check("tmo_good_data", MemData_o, 32'h8888_0008);
        check("tmo_err_sticky", {31'd0, err_o}, 32'd1);
`else
        // Without the timeout option WAIT lasts as long as the ack takes.
        step();
        MemRead_i = 1'b1;
        addr_i    = 32'h0000_0070;
        step();
        MemRead_i = 1'b0;
        repeat (300) step();
        settle();
        check("long_wait_req", {31'd0, mem_req_o}, 32'd1);
        check("long_wait_err", {31'd0, err_o}, 32'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h9999_0009;
        step();
        mem_ack_i = 1'b0;
        settle();
        check("long_done_data", MemData_o, 32'h9999_0009);
        check("long_done_req", {31'd0, mem_req_o}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
